// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL lock model and reset sequencer for the ice40 6502 system.
// Models PLL acquisition, then holds the system in reset for a fixed time,
// then releases a set of independent clock-enable strobes for the CPU, video
// and UART blocks. Every output comes straight from a register.

module pll_lock_seq #(
    parameter int                    LOCK_CYCLES = 16,
    parameter int                    HOLD_CYCLES = 8,
    parameter int                    NCE         = 2,
    parameter int                    DIV_W       = 8,
    parameter logic [NCE*DIV_W-1:0]  DIVS        = {8'd4, 8'd2}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           resetb,
    input  logic           bypass,
    output logic           lock,
    output logic           sys_rst,
    output logic [NCE-1:0] ce,
    output logic [1:0]     state
);

    // The shared counter only has to reach the larger of the two terminal
    // values; it is cleared on every terminal compare so it never wraps.
    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RUN     = 2'd3
    } stateT;

    stateT            state_q;
    logic             lock_q;
    logic             sysRst_q;
    logic             bypass_q;
    logic [NCE-1:0]   ce_q;
    logic [CNT_W-1:0] cnt_q;

    logic [DIV_W-1:0] divCnt_q [NCE];
    logic [DIV_W-1:0] divCnt_d [NCE];
    logic [NCE-1:0]   ceRun_d;

    logic             bypassEdge;

    // A bypass change only counts as an event once the sequencer has left
    // RESET; in RESET the new value is simply picked up on the way out.
    always_comb begin
        bypassEdge = (bypass != bypass_q) && (state_q != ST_RESET);
    end

    // Next value of each divider while running. A divider whose ratio is 0 or
    // 1 sits at zero, so its strobe is high on every RUN cycle. The strobe is
    // computed from the next count so the registered ce lines up with it.
    always_comb begin
        for (int i = 0; i < NCE; i++) begin
            divCnt_d[i] = '0;
            ceRun_d[i]  = 1'b1;
            if ((DIVS[i*DIV_W +: DIV_W] > DIV_W'(1)) &&
                (divCnt_q[i] < (DIVS[i*DIV_W +: DIV_W] - DIV_W'(1)))) begin
                divCnt_d[i] = divCnt_q[i] + DIV_W'(1);
                ceRun_d[i]  = 1'b0;
            end
        end
    end

    // Sequencer: resetb low beats everything, then a bypass change restarts
    // acquisition (or hold), otherwise the state walks RESET->ACQUIRE->HOLD->RUN.
    // Entering HOLD with lock still low (bypass path) spends one cycle raising
    // lock before the hold count starts, so the hold is always a full count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            lock_q   <= 1'b0;
            sysRst_q <= 1'b1;
            bypass_q <= 1'b0;
            ce_q     <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NCE; i++) begin
                divCnt_q[i] <= '0;
            end
        end else begin
            bypass_q <= bypass;
            ce_q     <= '0;
            if (!resetb) begin
                state_q  <= ST_RESET;
                lock_q   <= 1'b0;
                sysRst_q <= 1'b1;
                cnt_q    <= '0;
                for (int i = 0; i < NCE; i++) begin
                    divCnt_q[i] <= '0;
                end
            end else if (bypassEdge) begin
                state_q  <= bypass ? ST_HOLD : ST_ACQUIRE;
                lock_q   <= 1'b0;
                sysRst_q <= 1'b1;
                cnt_q    <= '0;
                for (int i = 0; i < NCE; i++) begin
                    divCnt_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    ST_RESET: begin
                        lock_q   <= 1'b0;
                        sysRst_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= bypass ? ST_HOLD : ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        sysRst_q <= 1'b1;
                        if (cnt_q == LOCK_LAST) begin
                            state_q <= ST_HOLD;
                            lock_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        sysRst_q <= 1'b1;
                        if (!lock_q) begin
                            lock_q <= 1'b1;
                            cnt_q  <= '0;
                        end else if (cnt_q == HOLD_LAST) begin
                            state_q  <= ST_RUN;
                            sysRst_q <= 1'b0;
                            cnt_q    <= '0;
                            ce_q     <= '1;
                            for (int i = 0; i < NCE; i++) begin
                                divCnt_q[i] <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        lock_q   <= 1'b1;
                        sysRst_q <= 1'b0;
                        ce_q     <= ceRun_d;
                        for (int i = 0; i < NCE; i++) begin
                            divCnt_q[i] <= divCnt_d[i];
                        end
                    end
                    default: begin
                        state_q  <= ST_RESET;
                        lock_q   <= 1'b0;
                        sysRst_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                endcase
            end
        end
    end

    assign lock    = lock_q;
    assign sys_rst = sysRst_q;
    assign ce      = ce_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: scoreboard bench for pll_lock_seq. Expected outputs are
// derived from the documented cycle timing, queued as each cycle's stimulus
// is driven and compared once the DUT has produced that cycle's outputs.
// A second instance with ratios {1,0} runs alongside to cover constant strobes.

module tb_pll_lock_seq;

    localparam int LOCK_CYCLES = 16;
    localparam int HOLD_CYCLES = 8;

    typedef struct {
        logic [1:0] state;
        logic       lock;
        logic       sysRst;
        logic [1:0] ce;
        logic [1:0] ceConst;
    } expT;

    logic       clk;
    logic       rst;
    logic       resetb;
    logic       bypass;
    logic       lock;
    logic       sysRst;
    logic [1:0] ce;
    logic [1:0] state;
    logic       lockConst;
    logic       sysRstConst;
    logic [1:0] ceConst;
    logic [1:0] stateConst;

    int checks;
    int failures;
    expT expQ [$];

    pll_lock_seq dut (
        .clk     (clk),
        .rst     (rst),
        .resetb  (resetb),
        .bypass  (bypass),
        .lock    (lock),
        .sys_rst (sysRst),
        .ce      (ce),
        .state   (state)
    );

    pll_lock_seq #(.DIVS({8'd1, 8'd0})) dutConst (
        .clk     (clk),
        .rst     (rst),
        .resetb  (resetb),
        .bypass  (bypass),
        .lock    (lockConst),
        .sys_rst (sysRstConst),
        .ce      (ceConst),
        .state   (stateConst)
    );

    // Free-running reference clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Outputs expected while the sequencer is held in RESET.
    function automatic expT resetExp();
        expT e;
        e.state   = 2'd0;
        e.lock    = 1'b0;
        e.sysRst  = 1'b1;
        e.ce      = 2'b00;
        e.ceConst = 2'b00;
        return e;
    endfunction

    // Outputs expected n cycles after the sequence was started (n=1 is the
    // first cycle after resetb=1 or a bypass change was sampled).
    function automatic expT seqExp(input bit byp, input int n);
        expT e;
        int lockAt;
        int runAt;
        lockAt = byp ? 2 : LOCK_CYCLES + 1;
        runAt  = lockAt + HOLD_CYCLES;
        if (n >= runAt)       e.state = 2'd3;
        else if (n >= lockAt) e.state = 2'd2;
        else                  e.state = byp ? 2'd2 : 2'd1;
        e.lock    = (n >= lockAt);
        e.sysRst  = (n < runAt);
        e.ce[0]   = (n >= runAt) && (((n - runAt) % 2) == 0);
        e.ce[1]   = (n >= runAt) && (((n - runAt) % 4) == 0);
        e.ceConst = (n >= runAt) ? 2'b11 : 2'b00;
        return e;
    endfunction

    // Pops the oldest expectation and compares every observed output to it.
    task automatic compareNext(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard empty", tag);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, ".state"}, {6'd0, state}, {6'd0, e.state});
        checkOutput({tag, ".lock"}, {7'd0, lock}, {7'd0, e.lock});
        checkOutput({tag, ".sys_rst"}, {7'd0, sysRst}, {7'd0, e.sysRst});
        checkOutput({tag, ".ce"}, {6'd0, ce}, {6'd0, e.ce});
        checkOutput({tag, ".ceConst"}, {6'd0, ceConst}, {6'd0, e.ceConst});
        checkOutput({tag, ".stateConst"}, {6'd0, stateConst}, {6'd0, e.state});
    endtask

    // Drives one cycle of inputs, queues what should come out, and checks
    // just after the edge that consumes them.
    task automatic applyStimulus(input logic rb, input logic bp, input expT e, input string tag);
        resetb = rb;
        bypass = bp;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        compareNext(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        resetb   = 1'b0;
        bypass   = 1'b0;

        // Async reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        expQ.push_back(resetExp());
        compareNext("rstAsync");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // resetb low keeps the sequencer parked in RESET.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, resetExp(), "idle");

        // Normal acquisition: lock at 17, release at 25, strobes from 25.
        for (int n = 1; n <= 40; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "acq");

        // One-cycle resetb drop in RUN, then a full re-acquisition.
        applyStimulus(1'b0, 1'b0, resetExp(), "dropRb");
        for (int n = 1; n <= 30; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "reacq");

        // Bypass start (resetb low overrides the simultaneous bypass change).
        applyStimulus(1'b0, 1'b1, resetExp(), "bypRst");
        for (int n = 1; n <= 20; n++) applyStimulus(1'b1, 1'b1, seqExp(1'b1, n), "byp");

        // Bypass 1->0 while running restarts a full acquisition.
        for (int n = 1; n <= 30; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "bypOff");

        // Bypass 0->1 at HOLD cnt=3 (cycle 20): lock drops, hold restarts.
        applyStimulus(1'b0, 1'b0, resetExp(), "holdRst");
        for (int n = 1; n <= 20; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "preToggle");
        for (int n = 21; n <= 40; n++) applyStimulus(1'b1, 1'b1, seqExp(1'b1, n - 20), "holdRestart");

        // Async rst mid-ACQUIRE, asserted between edges.
        applyStimulus(1'b0, 1'b0, resetExp(), "midRst");
        for (int n = 1; n <= 8; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "midAcq");
        #2 rst = 1'b1;
        #1;
        expQ.push_back(resetExp());
        compareNext("rstMidCycle");
        @(posedge clk);
        #1;
        expQ.push_back(resetExp());
        compareNext("rstHeld");
        #1 rst = 1'b0;
        for (int n = 1; n <= 30; n++) applyStimulus(1'b1, 1'b0, seqExp(1'b0, n), "afterRst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
